// File: rtl/vmem_responder.sv
// vmem_responder
// Memory-side responder for vector load/store traffic. Requests arrive one per
// cycle on a valid/ready handshake. Responses return in order through a
// 2-entry FIFO with its own valid/ready handshake, so the memory stage can be
// stalled by downstream back-pressure.
//
// Optional feature macro: VMEM_BYTE_WE_EN
//   defined   : stores write only the elements selected by req_be_i
//   undefined : req_be_i is ignored and stores write the full word
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active low
//   req_valid_i  in   request present
//   req_ready_o  out  request can be accepted (registered state only)
//   req_we_i     in   1 = store, 0 = load
//   req_a_i      in   byte address (W bits)
//   req_wd_i     in   store data (W bits)
//   req_be_i     in   per-element write enable (VECT_SIZE bits)
//   rsp_valid_o  out  response present
//   rsp_ready_i  in   consumer takes the response
//   rsp_rd_o     out  load data, 0 for stores and errors
//   rsp_err_o    out  request was misaligned or out of range
module vmem_responder #(
  parameter int ELEM_SIZE  = 8,
  parameter int VECT_SIZE  = 8,
  parameter int MEMO_LINES = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] req_a_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] req_wd_i,
  input  logic [VECT_SIZE-1:0]           req_be_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] rsp_rd_o,
  output logic                           rsp_err_o
);

  localparam int W    = ELEM_SIZE * VECT_SIZE;
  localparam int OFFW = $clog2(W / 8);
  localparam int IDXW = (MEMO_LINES > 1) ? $clog2(MEMO_LINES) : 1;
  localparam logic [W-1:0] LINES_W = W'(MEMO_LINES);

  // Vector storage, intentionally not reset.
  logic [W-1:0] r_mem [MEMO_LINES];

  // Response FIFO: two entries addressed by 1-bit head/tail pointers.
  logic [W-1:0] r_fifo_rd [2];
  logic [1:0]   r_fifo_err;
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_count;

  logic            w_acc;
  logic            w_pop;
  logic            w_err;
  logic            w_wr;
  logic [W-1:0]    w_line;
  logic [IDXW-1:0] w_idx;
  logic [W-1:0]    w_rdata;
  logic [W-1:0]    w_wdata;
  logic [W-1:0]    w_push_rd;

  assign req_ready_o = (r_count != 2'd2);
  assign rsp_valid_o = (r_count != 2'd0);
  assign w_acc       = req_valid_i & req_ready_o;
  assign w_pop       = rsp_valid_o & rsp_ready_i;

  // The full shifted address is compared so high address bits can never alias
  // onto a valid line.
  assign w_line = req_a_i >> OFFW;
  assign w_idx  = w_line[IDXW-1:0];
  assign w_err  = (req_a_i[OFFW-1:0] != '0) || (w_line >= LINES_W);

  assign w_rdata   = r_mem[w_idx];
  assign w_push_rd = (!req_we_i && !w_err) ? w_rdata : '0;
  assign w_wr      = w_acc & req_we_i & ~w_err;

`ifdef VMEM_BYTE_WE_EN
  // Merge the selected elements of the store data over the current line.
  always_comb begin
    w_wdata = w_rdata;
    for (int i = 0; i < VECT_SIZE; i++) begin
      if (req_be_i[i]) begin
        w_wdata[i*ELEM_SIZE +: ELEM_SIZE] = req_wd_i[i*ELEM_SIZE +: ELEM_SIZE];
      end
    end
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^req_be_i;
  assign w_wdata     = req_wd_i;
`endif

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_fifo_rd[0] <= '0;
      r_fifo_rd[1] <= '0;
      r_fifo_err   <= 2'b00;
    end else begin
      if (w_acc) begin
        r_fifo_rd[r_tail]  <= w_push_rd;
        r_fifo_err[r_tail] <= w_err;
        r_tail             <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are forced to zero when empty so stale entries never leak out.
  assign rsp_rd_o  = rsp_valid_o ? r_fifo_rd[r_head] : '0;
  assign rsp_err_o = rsp_valid_o ? r_fifo_err[r_head] : 1'b0;

endmodule

// File: tb/tb_vmem_responder.sv
// Bench for vmem_responder: randomized and directed traffic, with a request
// monitor that predicts each response from a word-array reference model and a
// response monitor that pops and compares in order.
module tb_vmem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_a_i;
  logic [63:0] req_wd_i;
  logic [7:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rd_o;
  logic        rsp_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] rd;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [63:0] model_mem [64];

`ifdef VMEM_BYTE_WE_EN
  localparam logic [63:0] BE_EXP = 64'h00000000FFFFFFFF;
`else
  localparam logic [63:0] BE_EXP = 64'hFFFFFFFFFFFFFFFF;
`endif

  vmem_responder #(.ELEM_SIZE(8), .VECT_SIZE(8), .MEMO_LINES(64)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_a_i     (req_a_i),
    .req_wd_i    (req_wd_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rd_o    (rsp_rd_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Both monitors sample mid-cycle; inputs only change 1 time unit after posedge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      rsp_t        e;
      logic [63:0] idx;
      logic        err;
      chk("rsp_valid_vs_pending", {63'd0, rsp_valid_o}, {63'd0, exp_q.size() != 0});
      chk("req_ready_vs_pending", {63'd0, req_ready_o}, {63'd0, exp_q.size() < 2});
      if (!rsp_valid_o) begin
        chk("idle_rd_zero", rsp_rd_o, 64'd0);
        chk("idle_err_zero", {63'd0, rsp_err_o}, 64'd0);
      end else if (rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected actual=valid required=none_pending");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rd", rsp_rd_o, e.rd);
          chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e.err});
        end
      end
      // Reference model: a request accepted at the next edge is resolved now.
      if (req_valid_i && req_ready_o) begin
        idx = req_a_i / 8;
        err = (req_a_i % 8 != 0) || (idx >= 64);
        e.err = err;
        e.rd  = 64'd0;
        if (!err) begin
          if (req_we_i) begin
`ifdef VMEM_BYTE_WE_EN
            for (int i = 0; i < 8; i++)
              if (req_be_i[i]) model_mem[idx][8*i +: 8] = req_wd_i[8*i +: 8];
`else
            model_mem[idx] = req_wd_i;
`endif
          end else begin
            e.rd = model_mem[idx];
          end
        end
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] be, input logic rr);
    @(posedge clk_i);
    #1;
    req_valid_i = v;
    req_we_i    = we;
    req_a_i     = a;
    req_wd_i    = wd;
    req_be_i    = be;
    rsp_ready_i = rr;
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 8'h00, rr);
  endtask

  task automatic issue(input logic we, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] be, input logic rr);
    bit done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      drive(1'b1, we, a, wd, be, rr);
      done = req_ready_o;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL issue_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 64'($urandom_range(0, 63)) * 8 + 64'($urandom_range(1, 7));
    if (r == 1) return 64'($urandom_range(64, 300)) * 8;
    if (r == 2) return {$urandom, $urandom} & ~64'h7;
    return 64'($urandom_range(0, 63)) * 8;
  endfunction

  initial begin
    logic [63:0] d;
    logic [63:0] saved;
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_a_i     = '0;
    req_wd_i    = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b1;
    #2;
    chk("reset_ready", {63'd0, req_ready_o}, 64'd1);
    chk("reset_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("reset_rd", rsp_rd_o, 64'd0);
    chk("reset_err", {63'd0, rsp_err_o}, 64'd0);
    #10;
    rst_i = 1'b1;

    // Fill every line so the model knows the whole memory; full throughput.
    for (int i = 0; i < 64; i++) begin
      issue(1'b1, 64'(i) * 8, {$urandom, $urandom}, 8'hFF, 1'b1);
      chk("throughput_ready", {63'd0, req_ready_o}, 64'd1);
    end
    idle(1'b1);

    // Store then load the same line in back-to-back cycles.
    d = 64'h1122334455667788;
    drive(1'b1, 1'b1, 64'h40, d, 8'hFF, 1'b1);
    chk("st_accept", {63'd0, req_ready_o}, 64'd1);
    drive(1'b1, 1'b0, 64'h40, 64'd0, 8'h00, 1'b1);
    chk("ld_accept_no_stall", {63'd0, req_ready_o}, 64'd1);
    chk("st_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("st_rsp_rd", rsp_rd_o, 64'd0);
    idle(1'b1);
    chk("ld_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("ld_rsp_rd", rsp_rd_o, d);
    idle(1'b1);

    // Back-pressure: third load waits until the cycle after the first pop.
    drive(1'b1, 1'b0, 64'h00, 64'd0, 8'h00, 1'b0);
    chk("bp_acc1", {63'd0, req_ready_o}, 64'd1);
    drive(1'b1, 1'b0, 64'h08, 64'd0, 8'h00, 1'b0);
    chk("bp_acc2", {63'd0, req_ready_o}, 64'd1);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 8'h00, 1'b0);
    chk("bp_full_ready", {63'd0, req_ready_o}, 64'd0);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 8'h00, 1'b0);
    chk("bp_full_hold", {63'd0, req_ready_o}, 64'd0);
    chk("bp_head_stable", rsp_rd_o, model_mem[0]);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 8'h00, 1'b1);
    chk("bp_pop_cycle_ready", {63'd0, req_ready_o}, 64'd0);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 8'h00, 1'b1);
    chk("bp_acc3_after_pop", {63'd0, req_ready_o}, 64'd1);
    chk("bp_second_rsp", rsp_rd_o, model_mem[1]);
    idle(1'b1);
    idle(1'b1);

    // Error requests leave memory untouched.
    issue(1'b1, 64'h43, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
    issue(1'b1, 64'h200, 64'hCAFECAFECAFECAFE, 8'hFF, 1'b1);
    chk("err_misaligned", {63'd0, rsp_err_o}, 64'd1);
    chk("err_misaligned_rd", rsp_rd_o, 64'd0);
    issue(1'b0, 64'h40, 64'd0, 8'h00, 1'b1);
    chk("err_range", {63'd0, rsp_err_o}, 64'd1);
    idle(1'b1);
    chk("err_ld_unchanged", rsp_rd_o, d);
    idle(1'b1);

    // Partial element write.
    issue(1'b1, 64'h28, 64'd0, 8'hFF, 1'b1);
    issue(1'b1, 64'h28, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1);
    issue(1'b0, 64'h28, 64'd0, 8'h00, 1'b1);
    idle(1'b1);
    chk("be_readback", rsp_rd_o, BE_EXP);
    idle(1'b1);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
            {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset with the FIFO full: entries drop at once, memory survives.
    saved = model_mem[9];
    issue(1'b0, 64'h48, 64'd0, 8'h00, 1'b0);
    issue(1'b0, 64'h50, 64'd0, 8'h00, 1'b0);
    idle(1'b0);
    chk("full_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("full_ready", {63'd0, req_ready_o}, 64'd0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("midrst_rd", rsp_rd_o, 64'd0);
    chk("midrst_err", {63'd0, rsp_err_o}, 64'd0);
    exp_q.delete();
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    issue(1'b0, 64'h48, 64'd0, 8'h00, 1'b1);
    idle(1'b1);
    chk("post_rst_data", rsp_rd_o, saved);

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vmem_responder.md
# vmem_responder

Memory-side responder for vector load/store traffic issued by the memory stage. It accepts one request per cycle over a valid/ready handshake and holds `MEMO_LINES` vector words in a register array. It returns exactly one response per accepted request, in order, through a 2-entry response FIFO with its own valid/ready handshake. It replaces the bare always-ready data memory, so that the memory stage can be stalled by downstream back-pressure.

## Interface
Parameters:
- `ELEM_SIZE`, 8: bits per vector element.
- `VECT_SIZE`, 8: elements per vector word (word width W = `ELEM_SIZE*VECT_SIZE` = 64).
- `MEMO_LINES`, 64: number of vector words stored.

Ports:
- `clk_i`, in, 1: single clock, all logic on rising edge.
- `rst_i`, in, 1: reset, asynchronous assert, active-low.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: responder can accept the request.
- `req_we_i`, in, 1: 1 = store, 0 = load.
- `req_a_i`, in, W: byte address.
- `req_wd_i`, in, W: store data.
- `req_be_i`, in, `VECT_SIZE`: per-element write enable; only used with the macro.
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: consumer takes the response.
- `rsp_rd_o`, out, W: load data; 0 for stores and errors.
- `rsp_err_o`, out, 1: request was misaligned or out of range.

## Operation
- **Accept:** `acc = req_valid_i & req_ready_o`. `req_ready_o = (count < 2)`. The ready output depends only on registered state and never on `rsp_ready_i`.
- **Address decode:**
  - Word offset bits are `req_a_i[log2(W/8)-1:0]`; for W = 64 these are `[2:0]`.
  - Line index = `req_a_i >> log2(W/8)`.
  - Error when the offset is nonzero or the index is `>= MEMO_LINES`.
- **Store, no error:** the line is written at the accept edge. The response is `rd=0, err=0`.
- **Load, no error:** the line is read combinationally at accept and captured into the FIFO. The response is `rd=line, err=0`.
- **Error (load or store):** memory is unchanged. The response is `rd=0, err=1`.
- **Response FIFO:**
  - 2 entries, holding {rd, err}, with `count` in 0..2.
  - Push on `acc`. Pop on `rsp_valid_o & rsp_ready_i`.
  - Simultaneous push and pop leaves `count` unchanged and keeps order.
  - `rsp_valid_o = (count != 0)`. `rsp_rd_o` and `rsp_err_o` show the head entry and hold stable while valid and not popped.
- **Full:** at `count == 2`, `req_ready_o = 0`. Requests held on the input are not accepted and memory is not written.
- **Empty:** at `count == 0`, `rsp_valid_o = 0`. `rsp_rd_o` and `rsp_err_o` are 0.
- **Ordering:** a load accepted in the cycle after a store to the same line returns the new data. A load and store never occur in the same cycle (one request per cycle).

## Timing
- **Reset values:** `req_ready_o=1`, `rsp_valid_o=0`, `rsp_rd_o=0`, `rsp_err_o=0`, `count=0`.
- **Memory contents** are not reset and are undefined until written.
- **Reset mid-operation:**
  - All FIFO entries are dropped immediately (asynchronous).
  - Memory keeps its contents, except a write whose accept edge coincides with reset assertion, which is not guaranteed.
- **Latency:** accept at edge N → response visible after edge N (`rsp_valid_o` high in cycle N+1). This is a 1-cycle latency.
- **Throughput:** with `rsp_ready_i` held at 1, one request is accepted every cycle and `count` stays ≤ 1.
- **Back-pressure:** with `rsp_ready_i=0`, two requests are accepted, then `req_ready_o` drops in the cycle after the second accept. It rises in the cycle after the first pop.

## Configuration
- **`VMEM_BYTE_WE_EN` defined:** a store writes only elements `i` with `req_be_i[i]=1`; other elements keep their old values. A store with `req_be_i=0` still returns a normal response.
- **`VMEM_BYTE_WE_EN` undefined:** `req_be_i` is ignored and every store writes the full W-bit word.

## Test plan
- **Reset:** assert `rst_i=0` mid-cycle → outputs read 1/0/0/0 without waiting for a clock edge; `count=0`.
- **Store then load:** store `0x1122334455667788` to address `0x40`, then load `0x40` in the next cycle with `rsp_ready_i=1`. Expect the store response (rd=0, err=0) in cycle 1 and the load response (rd=`0x1122334455667788`) in cycle 2, with no stall.
- **Back-pressure:** with `rsp_ready_i=0`, issue loads to `0x00`, `0x08`, `0x10`. Expect only two accepts and `req_ready_o=0`. Then raise `rsp_ready_i` → responses arrive in order and the third load is accepted in the cycle after the first pop.
- **Errors:** store to `0x43` (misaligned) and to `0x200` (index 64, out of range) → both return `err=1`, `rd=0`. A following load of `0x40` returns the previous data unchanged.
- **Byte enables:** with the macro, `0xFFFF…FF` written over zeros with `req_be_i=0x0F` reads back `0x00000000FFFFFFFF`. Without the macro, the same writes read back `0xFFFFFFFFFFFFFFFF`.
- **Reset with FIFO full:** assert reset while 2 responses are pending → `rsp_valid_o=0` immediately. After release, a load returns data stored before the reset.
